// File: rtl/request_latch4_if.sv
// Request/acknowledge bundle between the request conditioner and the arbiter/encoder stage.
interface request_latch4_if #(
  parameter int unsigned N         = 4,
  parameter int unsigned SEL_WIDTH = 2
);
  logic [N-1:0]         I;
  logic                 ACK;
  logic [SEL_WIDTH-1:0] ACK_SEL;
  logic [N-1:0]         O;
  logic                 VALID;
  logic [N-1:0]         OVERRUN;

  modport master (output I, output ACK, output ACK_SEL, input O, input VALID, input OVERRUN);
  modport slave  (input I, input ACK, input ACK_SEL, output O, output VALID, output OVERRUN);
endinterface

// File: rtl/request_latch4.sv
// Per-channel synchronize, debounce and rising-edge detect; events latch as sticky
// pending bits cleared by an encoded acknowledge.
module request_latch4 #(
  parameter int unsigned N         = 4,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  request_latch4_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE - 1);

  logic [N-1:0]         sync1;
  logic [N-1:0]         sync2;
  logic [N-1:0]         db;
  logic [N-1:0]         db_q;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic [N-1:0]         o_q;
  logic [N-1:0]         ovr_q;

  logic [N-1:0]         rise;
  logic [N-1:0]         clr;
  logic [N-1:0]         o_nxt;
  logic [N-1:0]         ovr_nxt;

  // Pending/overrun next state; a new rise always wins over a same-cycle clear.
  always_comb begin
    rise    = db & ~db_q;
    clr     = '0;
    if (bus.ACK) begin
      clr = N'(1) << bus.ACK_SEL;
    end
    o_nxt   = rise | (o_q & ~clr);
    ovr_nxt = ovr_q | (rise & o_q & ~clr);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      o_q   <= '0;
      ovr_q <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      sync1 <= bus.I;
      sync2 <= sync1;
      db_q  <= db;
      o_q   <= o_nxt;
      ovr_q <= ovr_nxt;
      // Level is accepted only after DEBOUNCE consecutive mismatching samples.
      for (int unsigned k = 0; k < N; k++) begin
        if (sync2[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_MAX) begin
          db[k]  <= sync2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.O       = o_q;
  assign bus.OVERRUN = ovr_q;
  assign bus.VALID   = |o_q;

endmodule

// File: tb/tb_request_latch4.sv
// Directed bench for request_latch4 with a cycle-tagged expectation queue and a
// separate monitor that compares O/OVERRUN/VALID when each tagged cycle arrives.
module tb_request_latch4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int         target;
    logic [3:0] o;
    logic [3:0] ovr;
    logic       valid;
    string      name;
  } exp_t;

  exp_t q[$];

  request_latch4_if #(.N(4), .SEL_WIDTH(2)) bus ();

  request_latch4 #(.N(4), .SEL_WIDTH(2), .DEBOUNCE(4), .CNT_WIDTH(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expectation valid once k more rising edges have occurred.
  task automatic expect_after(input int k, input logic [3:0] o, input logic [3:0] ovr,
                              input string name);
    exp_t e;
    e.target = cyc + k;
    e.o      = o;
    e.ovr    = ovr;
    e.valid  = |o;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic ack(input logic [1:0] sel);
    bus.ACK     = 1'b1;
    bus.ACK_SEL = sel;
    tick(1);
    bus.ACK     = 1'b0;
  endtask

  // Monitor: pops every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].target <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.target < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.target, cyc);
      end else if (bus.O !== e.o || bus.OVERRUN !== e.ovr || bus.VALID !== e.valid) begin
        errors++;
        $display("FAIL %s: got O=%b OVERRUN=%b VALID=%b, want O=%b OVERRUN=%b VALID=%b",
                 e.name, bus.O, bus.OVERRUN, bus.VALID, e.o, e.ovr, e.valid);
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.I       = 4'b0000;
    bus.ACK     = 1'b0;
    bus.ACK_SEL = 2'd0;
    tick(2);

    // Reset held with all inputs high: nothing may latch.
    bus.I = 4'b1111;
    expect_after(3,  4'b0000, 4'b0000, "reset_hold_3");
    expect_after(6,  4'b0000, 4'b0000, "reset_hold_6");
    expect_after(10, 4'b0000, 4'b0000, "reset_hold_10");
    tick(10);
    rst = 1'b0;
    expect_after(6, 4'b0000, 4'b0000, "post_reset_edge5");
    expect_after(7, 4'b1111, 4'b0000, "post_reset_edge6");
    tick(8);
    bus.I = 4'b0000;
    for (int k = 0; k < 4; k++) ack(2'(k));
    expect_after(0, 4'b0000, 4'b0000, "post_reset_acked");
    tick(10);

    // Latency on ch2 and a too-short pulse on ch1.
    bus.I = 4'b0100;
    expect_after(6, 4'b0000, 4'b0000, "latency_edge5");
    expect_after(7, 4'b0100, 4'b0000, "latency_edge6");
    tick(7);
    bus.I = 4'b0110;
    tick(3);
    bus.I = 4'b0100;
    tick(10);
    expect_after(0, 4'b0100, 4'b0000, "short_pulse_ignored");
    tick(1);

    // Acknowledge by index, including a non-pending channel.
    expect_after(1, 4'b0000, 4'b0000, "ack_ch2");
    ack(2'd2);
    bus.I = 4'b1110;
    expect_after(8, 4'b1010, 4'b0000, "set_1010");
    tick(8);
    expect_after(1, 4'b0010, 4'b0000, "ack_ch3");
    ack(2'd3);
    expect_after(1, 4'b0010, 4'b0000, "ack_not_pending");
    ack(2'd0);
    expect_after(1, 4'b0000, 4'b0000, "ack_ch1_empty");
    ack(2'd1);

    // Rise on ch0 coincides with ACK of ch0 while pending.
    bus.I = 4'b1111;
    expect_after(8, 4'b0001, 4'b0000, "ch0_first_event");
    tick(8);
    bus.I = 4'b1110;
    tick(10);
    bus.I = 4'b1111;
    tick(6);
    expect_after(1, 4'b0001, 4'b0000, "set_wins_clear");
    ack(2'd0);
    expect_after(1, 4'b0000, 4'b0000, "ch0_cleared");
    ack(2'd0);

    // Overrun on ch3: two events without an ack in between.
    bus.I = 4'b0111;
    tick(10);
    bus.I = 4'b1111;
    expect_after(8, 4'b1000, 4'b0000, "ch3_first_event");
    tick(8);
    bus.I = 4'b0111;
    tick(10);
    bus.I = 4'b1111;
    expect_after(8, 4'b1000, 4'b1000, "ch3_overrun");
    tick(8);
    expect_after(1, 4'b0000, 4'b1000, "overrun_sticky_after_ack");
    ack(2'd3);

    // Reset mid-operation with a partial debounce count on ch0.
    bus.I = 4'b1001;
    tick(10);
    bus.I = 4'b1111;
    expect_after(8, 4'b0110, 4'b1000, "set_0110");
    tick(8);
    bus.I = 4'b1110;
    tick(4);
    rst = 1'b1;
    expect_after(1, 4'b0000, 4'b0000, "mid_reset_clear");
    tick(1);
    rst = 1'b0;
    expect_after(6, 4'b0000, 4'b0000, "requal_edge5");
    expect_after(7, 4'b1110, 4'b0000, "requal_edge6");
    tick(8);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
